// File: rtl/shiftreg_mode_pkg.sv
// Shared encodings for the prescaled LED shift register: mode select and step direction.
package shiftreg_mode_pkg;

  localparam logic [1:0] MODE_ROL      = 2'b00;
  localparam logic [1:0] MODE_ROR      = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags a step when the count reaches i_period.
module tick_gen #(
  parameter int unsigned NB_COUNT = 8
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_clear,
  input  logic [NB_COUNT-1:0] i_period,
  output logic                o_step
);

  logic [NB_COUNT-1:0] count_q, count_d;
  logic                wrap;

  // >= rather than == so a period shrunk below the count fires at once instead of wrapping.
  assign wrap   = (count_q >= i_period);
  assign o_step = i_enable & wrap;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shiftreg_mode.sv
// LED pattern register advanced by an internal prescaled tick; rotate, ping-pong, hold or load.
module shiftreg_mode #(
  parameter int unsigned NB_SHIFT = 4,
  parameter int unsigned NB_COUNT = 8
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic                i_load,
  input  logic [NB_SHIFT-1:0] i_load_data,
  input  logic [NB_COUNT-1:0] i_period,
  output logic [NB_SHIFT-1:0] o_shift,
  output logic                o_tick,
  output logic                o_dir
);
  import shiftreg_mode_pkg::*;

  logic [NB_SHIFT-1:0] shift_q, shift_d;
  logic                dir_q, dir_d;
  logic                tick_q, tick_d;
  logic                step;
  logic [NB_SHIFT-1:0] rol, ror;

  tick_gen #(
    .NB_COUNT (NB_COUNT)
  ) u_tick_gen (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_clear  (i_load),
    .i_period (i_period),
    .o_step   (step)
  );

  assign rol = {shift_q[NB_SHIFT-2:0], shift_q[NB_SHIFT-1]};
  assign ror = {shift_q[0], shift_q[NB_SHIFT-1:1]};

  always_comb begin
    shift_d = shift_q;
    dir_d   = dir_q;
    tick_d  = step & ~i_load;
    if (i_load) begin
      shift_d = i_load_data;
    end else if (step) begin
      unique case (i_mode)
        MODE_ROL: begin
          shift_d = rol;
          dir_d   = DIR_LEFT;
        end
        MODE_ROR: begin
          shift_d = ror;
          dir_d   = DIR_RIGHT;
        end
        MODE_PINGPONG: begin
          // Bounce off whichever end the pattern is heading into.
          if (dir_q == DIR_LEFT && shift_q[NB_SHIFT-1]) begin
            dir_d = DIR_RIGHT;
          end else if (dir_q == DIR_RIGHT && shift_q[0]) begin
            dir_d = DIR_LEFT;
          end
          shift_d = (dir_d == DIR_RIGHT) ? ror : rol;
        end
        MODE_HOLD: begin
          shift_d = shift_q;
        end
        default: begin
          shift_d = shift_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      shift_q <= NB_SHIFT'(1);
      dir_q   <= DIR_LEFT;
      tick_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
    end
  end

  assign o_shift = shift_q;
  assign o_tick  = tick_q;
  assign o_dir   = dir_q;

endmodule

// File: tb/tb_shiftreg_mode.sv
// Directed bench for shiftreg_mode: vector table for the stepping modes, hand sequences for timing.
module tb_shiftreg_mode;
  import shiftreg_mode_pkg::*;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_enable = 1'b0;
  logic [1:0] i_mode = MODE_ROL;
  logic       i_load = 1'b0;
  logic [3:0] i_load_data = 4'b0000;
  logic [7:0] i_period = 8'd0;
  logic [3:0] o_shift;
  logic       o_tick;
  logic       o_dir;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] period;
    logic       en;
    logic       ld;
    logic [3:0] ld_data;
    logic [3:0] exp_shift;
    logic       exp_tick;
    logic       exp_dir;
  } vec_t;

  vec_t vecs[16];

  shiftreg_mode #(
    .NB_SHIFT (4),
    .NB_COUNT (8)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_mode      (i_mode),
    .i_load      (i_load),
    .i_load_data (i_load_data),
    .i_period    (i_period),
    .o_shift     (o_shift),
    .o_tick      (o_tick),
    .o_dir       (o_dir)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_clk();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] exp_shift;
    int         en_cnt;
    logic       exp_step;

    // Rotate left, period 0
    vecs[0]  = '{MODE_ROL, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0};
    vecs[1]  = '{MODE_ROL, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0};
    vecs[2]  = '{MODE_ROL, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0};
    vecs[3]  = '{MODE_ROL, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0};
    // Ping-pong, period 0
    vecs[4]  = '{MODE_PINGPONG, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0};
    vecs[5]  = '{MODE_PINGPONG, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0};
    vecs[6]  = '{MODE_PINGPONG, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0};
    vecs[7]  = '{MODE_PINGPONG, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b1};
    vecs[8]  = '{MODE_PINGPONG, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b1};
    vecs[9]  = '{MODE_PINGPONG, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1};
    vecs[10] = '{MODE_PINGPONG, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0};
    // Load beats a step, then rotate left, then hold
    vecs[11] = '{MODE_ROL, 8'd0, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0};
    vecs[12] = '{MODE_ROL, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b1, 1'b0};
    vecs[13] = '{MODE_ROL, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b1, 1'b0};
    vecs[14] = '{MODE_HOLD, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b1, 1'b0};
    vecs[15] = '{MODE_HOLD, 8'd0, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b1, 1'b0};

    // Reset and idle
    #100;
    check("reset_shift", 32'(o_shift), 32'h1);
    check("reset_dir", 32'(o_dir), 32'h0);
    check("reset_tick", 32'(o_tick), 32'h0);
    i_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      edge_clk();
      check("idle_shift", 32'(o_shift), 32'h1);
      check("idle_tick", 32'(o_tick), 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      i_mode      = vecs[i].mode;
      i_period    = vecs[i].period;
      i_enable    = vecs[i].en;
      i_load      = vecs[i].ld;
      i_load_data = vecs[i].ld_data;
      edge_clk();
      check($sformatf("vec%0d_shift", i), 32'(o_shift), 32'(vecs[i].exp_shift));
      check($sformatf("vec%0d_tick", i), 32'(o_tick), 32'(vecs[i].exp_tick));
      check($sformatf("vec%0d_dir", i), 32'(o_dir), 32'(vecs[i].exp_dir));
    end
    i_load = 1'b0;

    // Load clears the prescaler: two counts, load, then four more enabled edges to the step
    i_mode = MODE_ROL;
    i_period = 8'd3;
    i_enable = 1'b1;
    edge_clk();
    edge_clk();
    i_load = 1'b1;
    i_load_data = 4'b0001;
    edge_clk();
    check("clr_load_shift", 32'(o_shift), 32'h1);
    check("clr_load_tick", 32'(o_tick), 32'h0);
    i_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_clk();
      check("clr_wait_tick", 32'(o_tick), 32'h0);
    end
    edge_clk();
    check("clr_step_tick", 32'(o_tick), 32'h1);
    check("clr_step_shift", 32'(o_shift), 32'h2);

    // Load honoured with enable low
    i_enable = 1'b0;
    i_load = 1'b1;
    i_load_data = 4'b1010;
    edge_clk();
    check("load_noen_shift", 32'(o_shift), 32'ha);

    // Rotate right, period 3, enable toggling
    i_mode = MODE_ROR;
    i_load_data = 4'b0001;
    edge_clk();
    check("ror_load_shift", 32'(o_shift), 32'h1);
    i_load = 1'b0;
    exp_shift = 4'b0001;
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      i_enable = (i % 2 == 0);
      exp_step = 1'b0;
      if (i_enable) begin
        en_cnt++;
        if (en_cnt % 4 == 0) begin
          exp_step = 1'b1;
          exp_shift = {exp_shift[0], exp_shift[3:1]};
        end
      end
      edge_clk();
      check($sformatf("ror%0d_tick", i), 32'(o_tick), 32'(exp_step));
      check($sformatf("ror%0d_shift", i), 32'(o_shift), 32'(exp_shift));
      if (exp_step) check($sformatf("ror%0d_dir", i), 32'(o_dir), 32'h1);
    end
    check("ror_final_shift", 32'(o_shift), 32'h4);

    // Period shrink below current count
    i_mode = MODE_ROL;
    i_period = 8'd7;
    i_enable = 1'b1;
    i_load = 1'b1;
    i_load_data = 4'b0001;
    edge_clk();
    i_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_clk();
      check("shrink_wait_tick", 32'(o_tick), 32'h0);
    end
    i_period = 8'd2;
    edge_clk();
    check("shrink_step_tick", 32'(o_tick), 32'h1);
    check("shrink_step_shift", 32'(o_shift), 32'h2);
    edge_clk();
    check("shrink_after_tick", 32'(o_tick), 32'h0);

    // Async reset between edges while tick is high
    i_period = 8'd3;
    edge_clk();
    edge_clk();
    edge_clk();
    check("pre_rst_tick", 32'(o_tick), 32'h1);
    check("pre_rst_shift", 32'(o_shift), 32'h4);
    #3 i_reset = 1'b0;
    #1;
    check("async_rst_shift", 32'(o_shift), 32'h1);
    check("async_rst_tick", 32'(o_tick), 32'h0);
    check("async_rst_dir", 32'(o_dir), 32'h0);
    #2 i_reset = 1'b1;

    // Async reset clears a non-zero prescaler count
    i_period = 8'd7;
    for (int i = 0; i < 3; i++) edge_clk();
    #3 i_reset = 1'b0;
    #3 i_reset = 1'b1;
    i_period = 8'd1;
    edge_clk();
    check("cnt_rst_tick0", 32'(o_tick), 32'h0);
    check("cnt_rst_shift0", 32'(o_shift), 32'h1);
    edge_clk();
    check("cnt_rst_tick1", 32'(o_tick), 32'h1);
    check("cnt_rst_shift1", 32'(o_shift), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shiftreg_mode.md
Name: shiftreg_mode

Overview:
Parametrised successor of the 4-bit LED shift register. It holds an NB_SHIFT-bit pattern and advances it on an internal prescaled tick, so the bench or board no longer has to toggle i_enable by hand. Modes are rotate-left, rotate-right, ping-pong (bounce) and hold, plus a synchronous parallel load. The block sits between the board clock/switch inputs and the LED outputs.

Parameters:
NB_SHIFT, 4, width of the shift pattern (>= 2)
NB_COUNT, 8, width of the prescaler counter and i_period

Ports:
clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_enable  in  1  count enable; the prescaler advances only on cycles with i_enable=1
i_mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 hold
i_load  in  1  synchronous parallel load strobe
i_load_data  in  NB_SHIFT  pattern written on load
i_period  in  NB_COUNT  tick period minus one, in enabled cycles
o_shift  out  NB_SHIFT  current pattern
o_tick  out  1  one-cycle pulse, high in the cycle o_shift shows a stepped value
o_dir  out  1  direction of the last step: 0 = left (toward MSB), 1 = right

Behaviour:
- Reset (i_reset=0, asynchronous): o_shift = 1 (LSB set), o_dir = 0, o_tick = 0, counter = 0. Release is synchronous to the next edge.
- Prescaler: on an edge with i_enable=1, if counter >= i_period then counter <= 0 and step = 1; otherwise counter <= counter + 1. With i_enable=0 the counter holds. The >= compare means that lowering i_period below the current count fires on the next enabled edge, with no wrap.
- i_period = 0 gives a step on every enabled cycle.
- A step updates o_shift on the same edge that the counter wraps. o_tick is registered on that same edge, so latency from the wrapping edge to the visible new value is 0 cycles.
- Rotate left: o_shift <= {o_shift[NB_SHIFT-2:0], o_shift[NB_SHIFT-1]}; o_dir <= 0.
- Rotate right: o_shift <= {o_shift[0], o_shift[NB_SHIFT-1:1]}; o_dir <= 1.
- Ping-pong: let d be the current o_dir.
  - If d=0 and o_shift[NB_SHIFT-1]=1: d flips to 1 and the register rotates right.
  - If d=1 and o_shift[0]=1: d flips to 0 and the register rotates left.
  - Otherwise the register rotates in direction d.
  - o_dir takes the direction actually used.
  - An all-zero pattern stays zero.
- Hold: the prescaler still runs and o_tick still pulses; o_shift and o_dir are unchanged.
- Load priority: i_load=1 beats a step on the same edge.
  - o_shift <= i_load_data, counter <= 0, o_tick <= 0, o_dir unchanged.
  - Load is honoured regardless of i_enable.
- Mode changes are sampled at each step; there is no pipeline delay and no flush.
- Reset mid-operation aborts immediately; there is no partial state.

Decomposition:
- Shared package: mode encodings (MODE_ROL=2'b00, MODE_ROR=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11) and direction constants (DIR_LEFT=0, DIR_RIGHT=1).
- One sub-module, tick_gen: parametrised by NB_COUNT; inputs clock, i_reset, i_enable, i_clear (driven by load), i_period; output o_step (combinational wrap condition).
- The top level holds the pattern register, the direction register and the mode mux.

Test Plan:
1. Reset/idle: hold i_reset=0 for 100 ns -> o_shift=4'b0001, o_dir=0, o_tick=0. Release with i_enable=0 for 20 cycles -> no change.
2. Rotate left, i_period=0, i_enable=1 -> o_shift goes 0001,0010,0100,1000,0001 on consecutive edges, o_tick high every cycle.
3. Rotate right, i_period=3, i_enable toggling every cycle -> one step per 4 enabled cycles (every 8 clocks): 0001 -> 1000 -> 0100. o_dir=1.
4. Ping-pong, i_period=0 -> 0001,0010,0100,1000,0100,0010,0001,0010. o_dir goes 1 at the 1000->0100 step and 0 at the 0001->0010 step.
5. Load/priority: i_load=1, i_load_data=4'b0110 on the edge where a step would occur -> o_shift=0110, o_tick=0, counter=0. Then rotate left, period 0 -> 1100, 1001. Next, mode=hold -> o_shift frozen while o_tick keeps pulsing.
6. Period shrink and async reset:
   - counter=5 with i_period=7, then i_period changed to 2 -> step on the next enabled edge.
   - Pull i_reset low between clock edges mid-run -> o_shift=0001 and o_tick=0 immediately (before the next edge); counter=0.
